// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I instruction-memory loader.
// Holds the loader state encoding, failure codes and stream header size.
package rv32i_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_CSUM,
    S_VERIFY,
    S_DONE,
    S_ERROR
  } ld_state_t;

  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_RDBK    = 2'd3;

  localparam int HDR_BYTES = 2;

  // Mod-256 sum of the four bytes of a word.
  function automatic logic [7:0] byte_sum(input logic [31:0] w);
    return w[7:0] + w[15:8] + w[23:16] + w[31:24];
  endfunction

endpackage

// File: rtl/rv32i_byte_packer.sv
// Little-endian byte-to-word packer for the loader stream.
// o_valid pulses combinationally with the 4th byte of each word.
module rv32i_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic [7:0]  i_byte,
  input  logic        i_valid,
  output logic [31:0] o_word,
  output logic        o_valid
);

  logic [1:0]  r_idx;
  logic [23:0] r_acc;

  assign o_valid = i_valid && (r_idx == 2'd3);
  assign o_word  = {i_byte, r_acc};

  // Collect the low three bytes; the 4th is passed straight through.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_idx <= 2'd0;
      r_acc <= 24'd0;
    end else if (i_valid) begin
      unique case (r_idx)
        2'd0: r_acc[7:0]   <= i_byte;
        2'd1: r_acc[15:8]  <= i_byte;
        2'd2: r_acc[23:16] <= i_byte;
        2'd3: r_acc        <= r_acc;
      endcase
      r_idx <= r_idx + 2'd1;
    end
  end

endmodule

// File: rtl/rv32i_imem_loader.sv
// Streams an image into instruction memory port B, then reads it back.
// Holds the core in reset until a load has been checksummed both ways.
module rv32i_imem_loader
  import rv32i_pkg::*;
#(
  parameter int AWIDTH  = 12,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [AWIDTH-1:0] mem_addr_b,
  output logic [31:0]       mem_data_b,
  output logic              mem_we_b,
  input  logic [31:0]       mem_q_b,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  ld_state_t         r_state;
  logic [15:0]       r_n;
  logic [16:0]       r_widx;
  logic [16:0]       r_vcnt;
  logic [7:0]        r_ssum;
  logic [7:0]        r_csum;
  logic [7:0]        r_rsum;
  logic [31:0]       r_idle;
  logic [AWIDTH-1:0] r_addr;
  logic [31:0]       r_data;
  logic              r_we;
  logic              r_hold;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [1:0]        r_code;

  logic        w_rx_state;
  logic        w_accept;
  logic        w_pk_valid;
  logic [31:0] w_pk_word;
  logic [15:0] w_n_new;
  logic        w_len_bad;
  logic        w_last_word;
  logic [16:0] w_vnext;
  logic [7:0]  w_vsum;
  logic        w_vend;
  logic        w_idle_to;

  assign w_rx_state = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                      (r_state == S_DATA) || (r_state == S_CSUM);
  assign rx_ready    = w_rx_state;
  assign w_accept    = rx_valid && w_rx_state;
  assign w_n_new     = {rx_data, r_n[7:0]};
  assign w_len_bad   = (w_n_new == 16'd0) ||
                       (32'(w_n_new) > (32'd1 << AWIDTH));
  assign w_last_word = (r_widx + 17'd1) == {1'b0, r_n};
  assign w_vnext     = r_vcnt + 17'd1;
  assign w_vsum      = r_rsum + byte_sum(mem_q_b);
  assign w_vend      = r_vcnt == {1'b0, r_n};
  assign w_idle_to   = r_idle == 32'(TIMEOUT - 1);

  rv32i_byte_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (r_state != S_DATA),
    .i_byte  (rx_data),
    .i_valid (w_accept && (r_state == S_DATA)),
    .o_word  (w_pk_word),
    .o_valid (w_pk_valid)
  );

  assign mem_addr_b = r_addr;
  assign mem_data_b = r_data;
  assign mem_we_b   = r_we;
  assign cpu_hold   = r_hold;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign err_code   = r_code;

  // Loader FSM: header, data writes, checksum, readback verify.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_n     <= 16'd0;
      r_widx  <= 17'd0;
      r_vcnt  <= 17'd0;
      r_ssum  <= 8'd0;
      r_csum  <= 8'd0;
      r_rsum  <= 8'd0;
      r_idle  <= 32'd0;
      r_addr  <= '0;
      r_data  <= 32'd0;
      r_we    <= 1'b0;
      r_hold  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_code  <= 2'd0;
    end else begin
      r_we <= 1'b0;
      if (w_pk_valid) begin
        r_we   <= 1'b1;
        r_addr <= r_widx[AWIDTH-1:0];
        r_data <= w_pk_word;
        r_widx <= r_widx + 17'd1;
      end
      if (w_rx_state) begin
        r_idle <= w_accept ? 32'd0 : r_idle + 32'd1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_HDR0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_code  <= 2'd0;
            r_hold  <= 1'b1;
            r_busy  <= 1'b1;
            r_idle  <= 32'd0;
            r_ssum  <= 8'd0;
            r_widx  <= 17'd0;
          end
        end
        S_HDR0: begin
          if (w_accept) begin
            r_n[7:0] <= rx_data;
            r_state  <= S_HDR1;
          end else if (w_idle_to) begin
            r_state <= S_ERROR;
            r_code  <= ERR_TIMEOUT;
          end
        end
        S_HDR1: begin
          if (w_accept) begin
            r_n[15:8] <= rx_data;
            if (w_len_bad) begin
              r_state <= S_ERROR;
              r_code  <= ERR_LEN;
            end else begin
              r_state <= S_DATA;
            end
          end else if (w_idle_to) begin
            r_state <= S_ERROR;
            r_code  <= ERR_TIMEOUT;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_ssum <= r_ssum + rx_data;
            if (w_pk_valid && w_last_word) begin
              r_state <= S_CSUM;
            end
          end else if (w_idle_to) begin
            r_state <= S_ERROR;
            r_code  <= ERR_TIMEOUT;
          end
        end
        S_CSUM: begin
          if (w_accept) begin
            r_csum  <= rx_data;
            r_state <= S_VERIFY;
            r_addr  <= '0;
            r_vcnt  <= 17'd0;
            r_rsum  <= 8'd0;
          end else if (w_idle_to) begin
            r_state <= S_ERROR;
            r_code  <= ERR_TIMEOUT;
          end
        end
        S_VERIFY: begin
          r_vcnt <= w_vnext;
          if (r_vcnt != 17'd0) begin
            r_rsum <= w_vsum;
          end
          if (w_vnext < {1'b0, r_n}) begin
            r_addr <= w_vnext[AWIDTH-1:0];
          end
          if (w_vend) begin
            if (r_ssum != r_csum) begin
              r_state <= S_ERROR;
              r_code  <= ERR_CSUM;
            end else if (w_vsum != r_csum) begin
              r_state <= S_ERROR;
              r_code  <= ERR_RDBK;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_hold  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERROR: begin
          r_error <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_imem_loader.sv
// Self-checking bench for rv32i_imem_loader with a port-B memory model.
// Expected writes are queued as bytes are driven and popped on mem_we_b.
module tb_rv32i_imem_loader;

  localparam int AW = 12;
  localparam int TO = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW-1:0] mem_addr_b;
  logic [31:0]   mem_data_b;
  logic          mem_we_b;
  logic [31:0]   mem_q_b;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;

  rv32i_imem_loader #(.AWIDTH(AW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .mem_addr_b (mem_addr_b),
    .mem_data_b (mem_data_b),
    .mem_we_b   (mem_we_b),
    .mem_q_b    (mem_q_b),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic [31:0] mem [0:(1<<AW)-1];
  logic        corrupt;
  wr_t         exp_q[$];
  logic [31:0] img[$];
  int          errors;
  int          checks;
  int          nwrites;

  // Synchronous port-B memory; optional corruption of word 1 on read.
  always @(posedge clk) begin
    if (mem_we_b) mem[mem_addr_b] <= mem_data_b;
    if (corrupt && mem_addr_b == 1)
      mem_q_b <= mem[mem_addr_b] ^ 32'h0000_0001;
    else
      mem_q_b <= mem[mem_addr_b];
  end

  // Scoreboard: every write pulse must match the next queued write.
  always @(negedge clk) begin
    if (mem_we_b) begin
      wr_t e;
      nwrites++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected addr=%h data=%h expected no write",
                 mem_addr_b, mem_data_b);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr_b !== e.a || mem_data_b !== e.d) begin
          errors++;
          $display("FAIL write got %h@%h expected %h@%h",
                   mem_data_b, mem_addr_b, e.d, e.a);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!rx_ready) begin
      errors++;
      checks++;
      $display("FAIL rx_ready_wait got 0 expected 1");
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_timeout got %b expected 0", busy);
    end
  endtask

  task automatic run_stream(input logic [15:0] n, input int nw,
                            input logic [7:0] cs_xor, input bit poke);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'd0;
    pulse_start();
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = img[w][8*k +: 8];
        s = s + b;
        if (k == 3) exp_q.push_back('{a: w[AW-1:0], d: img[w]});
        if (poke && w == 0 && k == 1) start = 1'b1;
        send_byte(b);
        start = 1'b0;
      end
    end
    send_byte(s ^ cs_xor);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_ready, mem_we_b, busy, done, error, cpu_hold, err_code} !== 8'd0) begin
      errors++;
      $display("FAIL reset_flags got %b expected 0",
               {rx_ready, mem_we_b, busy, done, error, cpu_hold, err_code});
    end
    checks++;
    if ({mem_addr_b, mem_data_b} !== '0) begin
      errors++;
      $display("FAIL reset_mem got %h %h expected 0", mem_addr_b, mem_data_b);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    img = {32'h0000_0013, 32'h0010_0093};
    run_stream(16'd2, 2, 8'h00, 1'b0);
    wait_idle(100);
    checks++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      errors++;
      $display("FAIL basic_flags got %b expected 100", {done, error, cpu_hold});
    end
    checks++;
    if (mem[0] !== 32'h0000_0013 || mem[1] !== 32'h0010_0093) begin
      errors++;
      $display("FAIL basic_mem got %h %h expected 00000013 00100093",
               mem[0], mem[1]);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_pending got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_bad_csum();
    img = {32'h0000_0013, 32'h0010_0093};
    run_stream(16'd2, 2, 8'hB6, 1'b0);
    wait_idle(100);
    checks++;
    if ({done, error, cpu_hold, err_code} !== 5'b01110) begin
      errors++;
      $display("FAIL csum_flags got %b expected 01110",
               {done, error, cpu_hold, err_code});
    end
  endtask

  task automatic test_bad_len();
    logic [15:0] lens [2];
    int w0;
    lens[0] = 16'd0;
    lens[1] = 16'd4097;
    for (int i = 0; i < 2; i++) begin
      w0 = nwrites;
      pulse_start();
      send_byte(lens[i][7:0]);
      send_byte(lens[i][15:8]);
      rx_valid = 1'b0;
      wait_idle(100);
      checks++;
      if ({done, error, cpu_hold, err_code} !== 5'b01101) begin
        errors++;
        $display("FAIL len%0d_flags got %b expected 01101",
                 i, {done, error, cpu_hold, err_code});
      end
      checks++;
      if (nwrites != w0) begin
        errors++;
        $display("FAIL len%0d_writes got %0d expected 0", i, nwrites - w0);
      end
    end
  endtask

  task automatic test_timeout();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    rx_valid = 1'b0;
    wait_idle(TO + 20);
    checks++;
    if ({done, error, cpu_hold, err_code} !== 5'b01100) begin
      errors++;
      $display("FAIL timeout_flags got %b expected 01100",
               {done, error, cpu_hold, err_code});
    end
  endtask

  task automatic test_readback();
    corrupt = 1'b1;
    img = {32'h0000_0013, 32'h0010_0093};
    run_stream(16'd2, 2, 8'h00, 1'b0);
    wait_idle(100);
    corrupt = 1'b0;
    checks++;
    if ({done, error, cpu_hold, err_code} !== 5'b01111) begin
      errors++;
      $display("FAIL readback_flags got %b expected 01111",
               {done, error, cpu_hold, err_code});
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] bs [5];
    bs[0] = 8'h11; bs[1] = 8'h22; bs[2] = 8'h33; bs[3] = 8'h44; bs[4] = 8'h55;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    exp_q.push_back('{a: '0, d: 32'h4433_2211});
    for (int i = 0; i < 5; i++) send_byte(bs[i]);
    reset = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if ({rx_ready, mem_we_b, busy, done, error, cpu_hold, err_code} !== 8'd0) begin
      errors++;
      $display("FAIL midreset_flags got %b expected 0",
               {rx_ready, mem_we_b, busy, done, error, cpu_hold, err_code});
    end
    checks++;
    if ({mem_addr_b, mem_data_b} !== '0) begin
      errors++;
      $display("FAIL midreset_mem got %h %h expected 0", mem_addr_b, mem_data_b);
    end
    reset = 1'b0;
    img = {32'hCAFE_0001, 32'h1234_5678};
    run_stream(16'd2, 2, 8'h00, 1'b0);
    wait_idle(100);
    checks++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      errors++;
      $display("FAIL midreset_load got %b expected 100", {done, error, cpu_hold});
    end
  endtask

  task automatic test_back_to_back();
    img = {};
    for (int i = 0; i < 8; i++) img.push_back($urandom);
    run_stream(16'd8, 8, 8'h00, 1'b1);
    wait_idle(100);
    checks++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_flags got %b expected 100", {done, error, cpu_hold});
    end
    checks++;
    if (mem[7] !== img[7]) begin
      errors++;
      $display("FAIL b2b_mem7 got %h expected %h", mem[7], img[7]);
    end
  endtask

  task automatic test_full();
    int w0;
    img = {};
    for (int i = 0; i < (1 << AW); i++) img.push_back($urandom);
    w0 = nwrites;
    run_stream(16'(1 << AW), 1 << AW, 8'h00, 1'b0);
    wait_idle(10000);
    checks++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      errors++;
      $display("FAIL full_flags got %b expected 100", {done, error, cpu_hold});
    end
    checks++;
    if (nwrites - w0 != (1 << AW)) begin
      errors++;
      $display("FAIL full_writes got %0d expected %0d", nwrites - w0, 1 << AW);
    end
    checks++;
    if (mem[(1<<AW)-1] !== img[(1<<AW)-1] || mem[0] !== img[0]) begin
      errors++;
      $display("FAIL full_ends got %h %h expected %h %h", mem[0],
               mem[(1<<AW)-1], img[0], img[(1<<AW)-1]);
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    nwrites  = 0;
    corrupt  = 1'b0;
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    test_reset();
    test_basic();
    test_bad_csum();
    test_bad_len();
    test_timeout();
    test_readback();
    test_reset_mid();
    test_back_to_back();
    test_full();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_pending got %0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
